// File: rtl/gpu_def.sv
// rtl/gpu_def.sv - shared GPU scheduler definitions: fence encodings and dispatch state enum
package gpu_def;

   // Fence encodings already used by the scheduler
   localparam logic [1:0] SCHED_FENCE_NONE = 2'd0;
   localparam logic [1:0] SCHED_FENCE_ACQ  = 2'd1;
   localparam logic [1:0] SCHED_FENCE_REL  = 2'd2;

   // Dispatch-side names for the same encodings; 2'd3 is reserved and behaves as none
   localparam logic [1:0] FENCE_NONE = SCHED_FENCE_NONE;
   localparam logic [1:0] FENCE_ACQ  = SCHED_FENCE_ACQ;
   localparam logic [1:0] FENCE_REL  = SCHED_FENCE_REL;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHECK    = 3'd1,
      SEND_CM  = 3'd2,
      SEND_R0  = 3'd3,
      SEND_IF  = 3'd4,
      WAIT_REL = 3'd5
   } dispatch_state_e;

endpackage

// File: rtl/core_dispatch_ctrl.sv
// rtl/core_dispatch_ctrl.sv - task dispatch FSM driving the core message bus; optional stall counter under CORE_DISPATCH_STALL_CNT_EN
module core_dispatch_ctrl
   import gpu_def::*;
#(
   parameter int CORE_NUM    = 16,
   parameter int BUS_TO_CORE = 16,
   parameter int LEN_W       = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   task_valid,
   output logic                   task_ready,
   input  logic [CORE_NUM-1:0]    task_core_mask,
   input  logic [CORE_NUM-1:0]    task_r0_mask,
   input  logic [1:0]             task_fence,
   input  logic [LEN_W-1:0]       task_len,
   input  logic                   instr_valid,
   input  logic [BUS_TO_CORE-1:0] instr_data,
   output logic                   instr_ready,
   input  logic [CORE_NUM-1:0]    core_ready,
   input  logic                   core_ack,
   output logic [BUS_TO_CORE-1:0] mess_to_core,
   output logic                   core_mask_loading,
   output logic                   r0_mask_loading,
   output logic                   if_loading,
   output logic [CORE_NUM-1:0]    cur_mask,
   output logic                   stall,
   output logic                   err_empty
`ifdef CORE_DISPATCH_STALL_CNT_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);

   // Masks wider than the bus are truncated, narrower ones zero-extended
   localparam int COPY_W = (CORE_NUM < BUS_TO_CORE) ? CORE_NUM : BUS_TO_CORE;

   dispatch_state_e state, state_nxt, end_state;

   logic [CORE_NUM-1:0]    mask_q;
   logic [CORE_NUM-1:0]    r0_q;
   logic [1:0]             fence_q;
   logic [LEN_W-1:0]       cnt_q;
   logic                   rel_seen_q;
   logic                   accept;
   logic                   if_take;
   logic                   check_go;
   logic                   rel_go;
   logic [BUS_TO_CORE-1:0] cm_word;
   logic [BUS_TO_CORE-1:0] r0_word;

   // Collision/fence check: no target core busy, and optionally every core idle
   function automatic logic clear_to_send(input logic [CORE_NUM-1:0] mask,
                                          input logic [CORE_NUM-1:0] ready,
                                          input logic                need_all);
      return ((mask & ~ready) == '0) && (!need_all || (&ready));
   endfunction

   // task_ready also gated by reset so every output reads 0 while reset is held
   assign task_ready = (state == IDLE) & reset;
   assign accept     = task_valid & (state == IDLE) & reset;
   assign if_take    = (state == SEND_IF) & instr_valid & core_ack;
   assign check_go   = clear_to_send(mask_q, core_ready, fence_q == FENCE_ACQ);
   assign rel_go     = rel_seen_q & clear_to_send(mask_q, core_ready, 1'b0);
   assign end_state  = (fence_q == FENCE_REL) ? WAIT_REL : IDLE;

   // Fit the latched masks onto the bus width
   always_comb begin
      cm_word = '0;
      r0_word = '0;
      cm_word[COPY_W-1:0] = mask_q[COPY_W-1:0];
      r0_word[COPY_W-1:0] = r0_q[COPY_W-1:0];
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and state-decoded bus outputs; word held until core_ack
   always_comb begin
      state_nxt         = state;
      instr_ready       = 1'b0;
      mess_to_core      = '0;
      core_mask_loading = 1'b0;
      r0_mask_loading   = 1'b0;
      if_loading        = 1'b0;
      cur_mask          = '0;
      stall             = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (task_core_mask != '0)) state_nxt = CHECK;
         end
         CHECK: begin
            cur_mask = mask_q;
            if (check_go) state_nxt = SEND_CM;
            else          stall     = 1'b1;
         end
         SEND_CM: begin
            cur_mask          = mask_q;
            mess_to_core      = cm_word;
            core_mask_loading = 1'b1;
            if (core_ack) state_nxt = SEND_R0;
         end
         SEND_R0: begin
            cur_mask        = mask_q;
            mess_to_core    = r0_word;
            r0_mask_loading = 1'b1;
            if (core_ack) state_nxt = (cnt_q == '0) ? end_state : SEND_IF;
         end
         SEND_IF: begin
            cur_mask     = mask_q;
            mess_to_core = instr_data;
            if_loading   = instr_valid;
            instr_ready  = core_ack;
            if (if_take && (cnt_q == LEN_W'(1))) state_nxt = end_state;
         end
         WAIT_REL: begin
            cur_mask = mask_q;
            if (rel_go) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Descriptor latch and remaining-word counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q  <= '0;
         r0_q    <= '0;
         fence_q <= FENCE_NONE;
         cnt_q   <= '0;
      end else if (accept) begin
         mask_q  <= task_core_mask;
         r0_q    <= task_r0_mask;
         fence_q <= task_fence;
         cnt_q   <= task_len;
      end else if (if_take) begin
         cnt_q   <= cnt_q - LEN_W'(1);
      end
   end

   // Empty-mask error pulse; rel_seen marks the second WAIT_REL cycle onward
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_empty  <= 1'b0;
         rel_seen_q <= 1'b0;
      end else begin
         err_empty  <= accept & (task_core_mask == '0);
         rel_seen_q <= (state == WAIT_REL);
      end
   end

`ifdef CORE_DISPATCH_STALL_CNT_EN
   // Saturating count of stalled CHECK cycles, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          stall_cnt <= 16'h0000;
      else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h0001;
   end
`endif

endmodule
